// File: rtl/timer_keypad_loader.sv
// Keypad front end for the microwave countdown timer: digit entry, serial digit load, run/pause/done control.
// Optional done beep is built when LOADER_BEEP_EN is defined.
module timer_keypad_loader #(
  parameter int unsigned MAX_TENS    = 5,
  parameter int unsigned BEEP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_zero,
  output logic [3:0] data,
  output logic       loadn,
  output logic       en,
  output logic       tclrn,
  output logic [3:0] entry_mins,
  output logic [3:0] entry_tens,
  output logic [3:0] entry_ones,
  output logic       running,
  output logic       err,
  output logic       done,
  output logic       beep
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TENS);

  state_t     state_q, state_d;
  logic [3:0] mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0] data_q, data_d;
  logic       loadn_q, loadn_d, en_q, en_d, tclrn_q, tclrn_d, err_q, err_d;
  logic [1:0] idx_q, idx_d;
  logic       first_q, first_d;

  logic is_digit, is_start, is_clear;
  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_start = key_valid && (key_code == 4'd10);
  assign is_clear = key_valid && (key_code == 4'd11);

  always_comb begin
    state_d = state_q;
    mins_d  = mins_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    data_d  = data_q;
    loadn_d = loadn_q;
    en_d    = en_q;
    tclrn_d = 1'b1;
    err_d   = 1'b0;
    idx_d   = idx_q;
    first_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          mins_d = tens_q;
          tens_d = ones_q;
          ones_d = key_code;
        end else if (is_clear) begin
          mins_d = '0;
          tens_d = '0;
          ones_d = '0;
        end else if (is_start && ({mins_q, tens_q, ones_q} != '0)) begin
          if (tens_q > MAX_T) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            loadn_d = 1'b0;
            data_d  = mins_q;
            idx_d   = '0;
          end
        end
      end
      // data_q already holds the digit for the current index; stage the next one
      S_LOAD: begin
        if (idx_q == 2'd0) begin
          data_d = tens_q;
          idx_d  = 2'd1;
        end else if (idx_q == 2'd1) begin
          data_d = ones_q;
          idx_d  = 2'd2;
        end else begin
          data_d  = '0;
          loadn_d = 1'b1;
          en_d    = 1'b1;
          idx_d   = '0;
          first_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!first_q && timer_zero) begin
          en_d    = 1'b0;
          state_d = S_DONE;
        end else if (is_clear) begin
          en_d    = 1'b0;
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (is_start) begin
          en_d    = 1'b1;
          first_d = 1'b1;
          state_d = S_RUN;
        end else if (is_clear) begin
          tclrn_d = 1'b0;
          mins_d  = '0;
          tens_d  = '0;
          ones_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (key_valid) begin
          mins_d  = '0;
          tens_d  = '0;
          ones_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      mins_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      data_q  <= '0;
      loadn_q <= 1'b1;
      en_q    <= 1'b0;
      tclrn_q <= 1'b1;
      err_q   <= 1'b0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mins_q  <= mins_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      data_q  <= data_d;
      loadn_q <= loadn_d;
      en_q    <= en_d;
      tclrn_q <= tclrn_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

`ifdef LOADER_BEEP_EN
  localparam int unsigned BW = (BEEP_CYCLES > 2) ? $clog2(BEEP_CYCLES) : 1;
  logic          beep_q, beep_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    beep_d = beep_q;
    bcnt_d = bcnt_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      beep_d = 1'b1;
      bcnt_d = BW'(BEEP_CYCLES - 1);
    end else if (state_d != S_DONE) begin
      beep_d = 1'b0;
      bcnt_d = '0;
    end else if (beep_q) begin
      if (bcnt_q == '0) beep_d = 1'b0;
      else              bcnt_d = bcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      beep_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      beep_q <= beep_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

  assign data       = data_q;
  assign loadn      = loadn_q;
  assign en         = en_q;
  assign tclrn      = tclrn_q;
  assign err        = err_q;
  assign entry_mins = mins_q;
  assign entry_tens = tens_q;
  assign entry_ones = ones_q;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_timer_keypad_loader.sv
// Directed test of timer_keypad_loader: entry, load sequence, run/pause/done, reject, reset.
module tb_timer_keypad_loader;
  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic       timer_zero = 1'b0;
  logic [3:0] data, entry_mins, entry_tens, entry_ones;
  logic       loadn, en, tclrn, running, err, done, beep;

  int checks = 0;
  int errors = 0;

  timer_keypad_loader #(.MAX_TENS(5), .BEEP_CYCLES(4)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .timer_zero(timer_zero), .data(data), .loadn(loadn), .en(en), .tclrn(tclrn),
    .entry_mins(entry_mins), .entry_tens(entry_tens), .entry_ones(entry_ones),
    .running(running), .err(err), .done(done), .beep(beep)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = '0;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    timer_zero = 1'b0;
    tick();
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    do_reset();
    checks++; if ({entry_mins, entry_tens, entry_ones} !== 12'h000) begin errors++; $display("FAIL reset_entry: got %h exp 000", {entry_mins, entry_tens, entry_ones}); end
    checks++; if ({loadn, en, tclrn, err, done, running, beep} !== 7'b1010000) begin errors++; $display("FAIL reset_ctl: got %b exp 1010000", {loadn, en, tclrn, err, done, running, beep}); end
    checks++; if (data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d exp 0", data); end
  endtask

  task automatic test_load();
    logic [3:0] exp_d [3];
    exp_d[0] = 4'd1; exp_d[1] = 4'd3; exp_d[2] = 4'd0;
    do_reset();
    key(4'd1); key(4'd3); key(4'd0);
    checks++; if ({entry_mins, entry_tens, entry_ones} !== 12'h130) begin errors++; $display("FAIL entry_130: got %h exp 130", {entry_mins, entry_tens, entry_ones}); end
    key(4'd10);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({loadn, data} !== {1'b0, exp_d[i]}) begin errors++; $display("FAIL load_cyc%0d: loadn=%b data=%0d exp loadn=0 data=%0d", i, loadn, data, exp_d[i]); end
      if (i == 1) key_valid = 1'b1;
      key_code = 4'd11;
      tick();
      key_valid = 1'b0;
    end
    checks++; if ({loadn, en, running, data} !== {3'b111, 4'd0}) begin errors++; $display("FAIL load_end: got loadn=%b en=%b run=%b data=%0d exp 1 1 1 0", loadn, en, running, data); end
    checks++; if ({entry_mins, entry_tens, entry_ones} !== 12'h130) begin errors++; $display("FAIL entry_held: got %h exp 130", {entry_mins, entry_tens, entry_ones}); end
  endtask

  task automatic test_reject();
    do_reset();
    key(4'd1); key(4'd9); key(4'd9);
    key(4'd10);
    checks++; if ({err, loadn} !== 2'b11) begin errors++; $display("FAIL reject_err: err=%b loadn=%b exp 1 1", err, loadn); end
    tick();
    checks++; if ({err, loadn, running} !== 3'b010) begin errors++; $display("FAIL reject_after: err=%b loadn=%b run=%b exp 0 1 0", err, loadn, running); end
    checks++; if ({entry_mins, entry_tens, entry_ones} !== 12'h199) begin errors++; $display("FAIL reject_buf: got %h exp 199", {entry_mins, entry_tens, entry_ones}); end
  endtask

  task automatic test_done();
    int bc;
    do_reset();
    key(4'd0); key(4'd5);
    key(4'd10);
    tick(); tick(); tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL done_run: got %b exp 1", running); end
    timer_zero = 1'b1;
    tick();
    checks++; if ({running, en, done} !== 3'b110) begin errors++; $display("FAIL zero_mask: run=%b en=%b done=%b exp 1 1 0", running, en, done); end
    tick();
    timer_zero = 1'b0;
    checks++; if ({en, done, running} !== 3'b010) begin errors++; $display("FAIL done_enter: en=%b done=%b run=%b exp 0 1 0", en, done, running); end
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (beep === 1'b1) bc++;
      tick();
    end
`ifdef LOADER_BEEP_EN
    checks++; if (bc !== 4) begin errors++; $display("FAIL beep_len: got %0d exp 4", bc); end
`else
    checks++; if (bc !== 0) begin errors++; $display("FAIL beep_off: got %0d exp 0", bc); end
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b exp 1", done); end
    key(4'd4);
    checks++; if ({done, running, loadn} !== 3'b001) begin errors++; $display("FAIL done_exit: done=%b run=%b loadn=%b exp 0 0 1", done, running, loadn); end
    checks++; if ({entry_mins, entry_tens, entry_ones} !== 12'h000) begin errors++; $display("FAIL done_buf: got %h exp 000", {entry_mins, entry_tens, entry_ones}); end
  endtask

  task automatic test_pause();
    do_reset();
    key(4'd1); key(4'd0);
    key(4'd10);
    tick(); tick(); tick();
    key(4'd11);
    checks++; if ({en, running} !== 2'b00) begin errors++; $display("FAIL pause_en: en=%b run=%b exp 0 0", en, running); end
    key(4'd7);
    checks++; if ({en, entry_mins, entry_tens, entry_ones} !== {1'b0, 12'h010}) begin errors++; $display("FAIL pause_digit: en=%b buf=%h exp 0 010", en, {entry_mins, entry_tens, entry_ones}); end
    key(4'd10);
    checks++; if ({en, running} !== 2'b11) begin errors++; $display("FAIL resume: en=%b run=%b exp 1 1", en, running); end
    key(4'd11);
    key(4'd11);
    checks++; if ({tclrn, running, entry_mins, entry_tens, entry_ones} !== {2'b00, 12'h000}) begin errors++; $display("FAIL tclr: tclrn=%b run=%b buf=%h exp 0 0 000", tclrn, running, {entry_mins, entry_tens, entry_ones}); end
    tick();
    checks++; if (tclrn !== 1'b1) begin errors++; $display("FAIL tclr_pulse: got %b exp 1", tclrn); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    checks++; if ({entry_mins, entry_tens, entry_ones} !== 12'h234) begin errors++; $display("FAIL shift: got %h exp 234", {entry_mins, entry_tens, entry_ones}); end
    key(4'd11);
    key(4'd10);
    checks++; if ({err, loadn} !== 2'b01) begin errors++; $display("FAIL zero_start: err=%b loadn=%b exp 0 1", err, loadn); end
    tick();
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL zero_noload: got %b exp 1", loadn); end
    key(4'd1); key(4'd0);
    key(4'd10);
    tick();
    checks++; if ({loadn, data} !== {1'b0, 4'd1}) begin errors++; $display("FAIL load1: loadn=%b data=%0d exp 0 1", loadn, data); end
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    checks++; if ({loadn, en, running, data} !== {3'b100, 4'd0}) begin errors++; $display("FAIL reset_mid: loadn=%b en=%b run=%b data=%0d exp 1 0 0 0", loadn, en, running, data); end
    tick();
    checks++; if ({loadn, entry_mins, entry_tens, entry_ones} !== {1'b1, 12'h000}) begin errors++; $display("FAIL reset_idle: loadn=%b buf=%h exp 1 000", loadn, {entry_mins, entry_tens, entry_ones}); end
    key(4'd2);
    key(4'd10);
    tick(); tick(); tick();
    tick();
    timer_zero = 1'b1;
    key(4'd11);
    timer_zero = 1'b0;
    checks++; if ({done, running, en} !== 3'b100) begin errors++; $display("FAIL zero_wins: done=%b run=%b en=%b exp 1 0 0", done, running, en); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_reject();
    test_done();
    test_pause();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
